// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command FIFO in front of the 4-bit ALU. Issues one
// command at a time, holds the ALU inputs for SETTLE cycles, captures Y and
// the compare flags, and presents the result over valid/ready.
// Optional build macro ALU_FLAG_CHECK_EN adds the sticky flag_err output.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  output logic [1:0]               alu_S,
  output logic                     alu_enable,
  output logic [3:0]               alu_A,
  output logic [3:0]               alu_B,
  input  logic [4:0]               alu_Y,
  input  logic                     alu_AGB,
  input  logic                     alu_AEB,
  input  logic                     alu_ALB,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [4:0]               res_y,
  output logic [2:0]               res_flags,
  output logic [1:0]               res_op,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_FLAG_CHECK_EN
  ,
  output logic                     flag_err
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [9:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       alu_s_q, alu_s_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic             alu_en_q, alu_en_d;
  logic             res_valid_q, res_valid_d;
  logic [4:0]       res_y_q, res_y_d;
  logic [2:0]       res_flags_q, res_flags_d;
  logic [1:0]       res_op_q, res_op_d;

  logic       push, pop, empty, capture;
  logic [9:0] head;
  logic [2:0] flags_in;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];
  assign flags_in  = {alu_AGB, alu_AEB, alu_ALB};

  // Command storage; written only on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  // FIFO pointer and occupancy update; pop is requested by the FSM below.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer: IDLE pops a command, ISSUE holds the ALU inputs for SETTLE
  // cycles then captures, HOLD waits for the downstream handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_s_d     = alu_s_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_en_d    = alu_en_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_flags_d = res_flags_q;
    res_op_d    = res_op_q;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          capture     = 1'b1;
          res_y_d     = alu_Y;
          res_flags_d = flags_in;
          res_op_d    = alu_s_q;
          res_valid_d = 1'b1;
          alu_en_d    = 1'b0;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Launching the next command is shared by IDLE and the HOLD handoff.
    if (pop) begin
      alu_s_d  = head[9:8];
      alu_a_d  = head[7:4];
      alu_b_d  = head[3:0];
      alu_en_d = 1'b1;
      cnt_d    = CNT_W'(SETTLE - 1);
      state_d  = ISSUE;
    end
  end

  // Registered state, ALU drive and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_flags_q <= '0;
      res_op_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_en_q    <= alu_en_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_flags_q <= res_flags_d;
      res_op_q    <= res_op_d;
    end
  end

`ifdef ALU_FLAG_CHECK_EN
  logic flag_err_q, flag_err_d;
  logic flags_onehot;

  // Sticky error when a compare capture sees flags that are not one-hot.
  always_comb begin
    flags_onehot = (flags_in == 3'b100) || (flags_in == 3'b010) || (flags_in == 3'b001);
    flag_err_d   = flag_err_q;
    if (capture && (alu_s_q == 2'b10) && !flags_onehot) flag_err_d = 1'b1;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_err_q <= 1'b0;
    else        flag_err_q <= flag_err_d;
  end

  assign flag_err = flag_err_q;
`endif

  assign alu_S      = alu_s_q;
  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_enable = alu_en_q;
  assign res_valid  = res_valid_q;
  assign res_y      = res_y_q;
  assign res_flags  = res_flags_q;
  assign res_op     = res_op_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a SETTLE=1 instance checked through
// an expected-result queue, plus a SETTLE=3 instance for timing.
// Build with ALU_FLAG_CHECK_EN defined to also exercise flag_err.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- SETTLE=1 instance ----------------
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] alu_S;
  logic       alu_enable;
  logic [3:0] alu_A, alu_B;
  logic [4:0] alu_Y;
  logic       alu_AGB, alu_AEB, alu_ALB;
  logic       res_valid, res_ready = 1'b0;
  logic [4:0] res_y;
  logic [2:0] res_flags;
  logic [1:0] res_op;
  logic       busy;
  logic [2:0] fifo_count;
  logic       force_bad = 1'b0;
  logic [7:0] m1;
`ifdef ALU_FLAG_CHECK_EN
  logic       flag_err, flag_err3;
`endif

  // ---------------- SETTLE=3 instance ----------------
  logic       cmd_valid3 = 1'b0, cmd_ready3;
  logic [1:0] cmd_op3 = '0;
  logic [3:0] cmd_a3 = '0, cmd_b3 = '0;
  logic [1:0] alu_S3;
  logic       alu_enable3;
  logic [3:0] alu_A3, alu_B3;
  logic [4:0] alu_Y3;
  logic       alu_AGB3, alu_AEB3, alu_ALB3;
  logic       res_valid3, res_ready3 = 1'b0;
  logic [4:0] res_y3;
  logic [2:0] res_flags3;
  logic [1:0] res_op3;
  logic       busy3;
  logic [2:0] fifo_count3;
  logic [7:0] m3;

  // Behavioural ALU: {Y[4:0], AGB, AEB, ALB}
  function automatic logic [7:0] alu_fn(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] y;
    case (s)
      2'b00:   y = {1'b0, a} + {1'b0, b};
      2'b01:   y = {1'b0, a} - {1'b0, b};
      2'b10:   y = 5'b0;
      default: y = {1'b0, a & b};
    endcase
    return {y, (a > b), (a == b), (a < b)};
  endfunction

  assign m1 = alu_fn(alu_S, alu_A, alu_B);
  assign {alu_Y, alu_AGB, alu_AEB, alu_ALB} = force_bad ? {m1[7:3], 3'b110} : m1;
  assign m3 = alu_fn(alu_S3, alu_A3, alu_B3);
  assign {alu_Y3, alu_AGB3, alu_AEB3, alu_ALB3} = m3;

  alu_cmd_sequencer #(.DEPTH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_S(alu_S), .alu_enable(alu_enable), .alu_A(alu_A), .alu_B(alu_B),
    .alu_Y(alu_Y), .alu_AGB(alu_AGB), .alu_AEB(alu_AEB), .alu_ALB(alu_ALB),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_flags(res_flags), .res_op(res_op), .busy(busy), .fifo_count(fifo_count)
`ifdef ALU_FLAG_CHECK_EN
    , .flag_err(flag_err)
`endif
  );

  alu_cmd_sequencer #(.DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .alu_S(alu_S3), .alu_enable(alu_enable3), .alu_A(alu_A3), .alu_B(alu_B3),
    .alu_Y(alu_Y3), .alu_AGB(alu_AGB3), .alu_AEB(alu_AEB3), .alu_ALB(alu_ALB3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_y(res_y3),
    .res_flags(res_flags3), .res_op(res_op3), .busy(busy3), .fifo_count(fifo_count3)
`ifdef ALU_FLAG_CHECK_EN
    , .flag_err(flag_err3)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected results {op[1:0], y[4:0], flags[2:0]} in push order
  logic [9:0] exp_q[$];
  int         acc_q[$];

  // Monitor: every accepted result is compared against the queue head
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      acc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {6'b0, res_op, res_y, res_flags}, 16'hffff);
      end else begin
        chk("result", {6'b0, res_op, res_y, res_flags}, {6'b0, exp_q.pop_front()});
      end
    end
  end

  // Drive one command (called at posedge+1); records the expected result on acceptance
  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [4:0] ey, input logic [2:0] ef);
    int t;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 16'd0, 16'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back({op, ey, ef});
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin step(1); t++; end
    chk(name, 16'(exp_q.size()), 16'd0);
  endtask

  int en_hi;

  initial begin
    // ---- reset state ----
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_cmd_ready", {15'b0, cmd_ready}, 16'd1);
    chk("rst_res_valid", {15'b0, res_valid}, 16'd0);
    chk("rst_alu_enable", {15'b0, alu_enable}, 16'd0);
    chk("rst_fifo_count", {13'b0, fifo_count}, 16'd0);
    chk("rst_busy", {15'b0, busy}, 16'd0);
`ifdef ALU_FLAG_CHECK_EN
    chk("rst_flag_err", {15'b0, flag_err}, 16'd0);
`endif

    // ---- SETTLE=3: sub 1000-0011 = 00101, flags 100 ----
    cmd_valid3 = 1'b1; cmd_op3 = 2'b01; cmd_a3 = 4'b1000; cmd_b3 = 4'b0011;
    @(posedge clk); #1;  // E0
    cmd_valid3 = 1'b0;
    chk("s3_en_e0", {15'b0, alu_enable3}, 16'd0);
    en_hi = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (alu_enable3 && !res_valid3) en_hi++;
    end
    chk("s3_en_cycles", 16'(en_hi), 16'd3);
    step(1);  // E4
    chk("s3_en_e4", {15'b0, alu_enable3}, 16'd0);
    chk("s3_res", {5'b0, res_valid3, res_op3, res_y3, res_flags3}, {5'b0, 1'b1, 2'b01, 5'b00101, 3'b100});
    res_ready3 = 1'b1;
    step(2);
    chk("s3_done", {14'b0, res_valid3, busy3}, 16'd0);

    // ---- single add: 1100+0011 = 01111, flags 100 ----
    res_ready = 1'b1;
    push(2'b00, 4'b1100, 4'b0011, 5'b01111, 3'b100);  // E0
    chk("add_en_e0", {15'b0, alu_enable}, 16'd0);
    step(1);  // E1
    chk("add_en_e1", {14'b0, alu_enable, res_valid}, 16'b10);
    step(1);  // E2
    chk("add_en_e2", {14'b0, alu_enable, res_valid}, 16'b01);
    drain("add_drain");

    // ---- backpressure / fill ----
    res_ready = 1'b0;
    push(2'b00, 4'b0001, 4'b0010, 5'b00011, 3'b001);
    push(2'b01, 4'b0111, 4'b0010, 5'b00101, 3'b100);
    push(2'b11, 4'b1010, 4'b0110, 5'b00010, 3'b100);
    push(2'b10, 4'b0011, 4'b1001, 5'b00000, 3'b001);
    push(2'b00, 4'b1111, 4'b1111, 5'b11110, 3'b010);
    chk("full_ready", {15'b0, cmd_ready}, 16'd0);
    chk("full_count", {13'b0, fifo_count}, 16'd4);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'b0001; cmd_b = 4'b0001;
    step(2);
    cmd_valid = 1'b0;
    chk("sixth_rejected", {12'b0, cmd_ready, fifo_count}, 16'd4);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_stable", {5'b0, res_valid, res_op, res_y, res_flags},
          {5'b0, 1'b1, 2'b00, 5'b00011, 3'b001});
    end
    acc_q.delete();
    res_ready = 1'b1;
    drain("fill_drain");
    chk("fill_cadence", 16'(acc_q[acc_q.size()-1] - acc_q[0]), 16'd8);
    chk("fill_idle", {15'b0, busy}, 16'd0);

    // ---- compare / flag checking ----
    push(2'b10, 4'b0101, 4'b0101, 5'b00000, 3'b010);
    drain("cmp_eq");
`ifdef ALU_FLAG_CHECK_EN
    chk("flag_err_clean", {15'b0, flag_err}, 16'd0);
`endif
    force_bad = 1'b1;
    push(2'b10, 4'b0110, 4'b0010, 5'b00000, 3'b110);
    drain("cmp_bad");
    force_bad = 1'b0;
`ifdef ALU_FLAG_CHECK_EN
    chk("flag_err_set", {15'b0, flag_err}, 16'd1);
`endif
    push(2'b10, 4'b0010, 4'b0110, 5'b00000, 3'b001);
    drain("cmp_good");
`ifdef ALU_FLAG_CHECK_EN
    chk("flag_err_sticky", {15'b0, flag_err}, 16'd1);
`endif

    // ---- reset in the middle of ISSUE with two commands queued ----
    res_ready = 1'b0;
    push(2'b11, 4'b1100, 4'b1010, 5'b01000, 3'b100);
    push(2'b00, 4'b0101, 4'b0110, 5'b01011, 3'b001);
    push(2'b01, 4'b0011, 4'b0001, 5'b00010, 3'b100);
    push(2'b10, 4'b1000, 4'b1000, 5'b00000, 3'b010);
    res_ready = 1'b1;
    step(1);  // first result taken, second command now in ISSUE
    chk("mid_state", {12'b0, alu_enable, fifo_count}, {12'b0, 1'b1, 3'd2});
    rst_n = 1'b0;
    #1;
    chk("async_clear", {9'b0, alu_enable, res_valid, cmd_ready, busy, fifo_count},
        {9'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("post_rst_quiet", {12'b0, res_valid, fifo_count}, 16'd0);
    end
    push(2'b01, 4'b0010, 4'b0101, 5'b11101, 3'b001);
    drain("post_rst_drain");
    step(3);
    chk("final_idle", {14'b0, busy, res_valid}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
